// File: rtl/reduce_tree_pipe.sv
// Pipelined WIDTH-input bitwise reduction tree (AND/OR/XOR/NAND), one register per level,
// with a valid/ready handshake at both ends and full back-pressure.
`timescale 1ns/1ps
module reduce_tree_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LOG2W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [1:0]       out_op
);

    // All stage data packed back to back: stage k starts at WIDTH - (WIDTH >> (k-1)).
    localparam int unsigned DW = WIDTH - 1;

    logic [DW-1:0]         d_q, d_d;
    logic [LOG2W:1]        v_q, v_d;
    logic [LOG2W:1]        adv;
    logic [LOG2W:1][1:0]   op_q, op_d;

    function automatic logic red2(input logic a, input logic b, input logic [1:0] op);
        case (op)
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return a & b;  // AND and NAND share the tree; NAND inverts at the output
        endcase
    endfunction

    // Ready chain: a stage may load when it is empty or the stage above is moving.
    always_comb begin
        logic a;
        a = out_ready;
        for (int k = LOG2W; k >= 1; k--) begin
            a      = ~v_q[k] | a;
            adv[k] = a;
        end
    end

    always_comb begin
        v_d  = v_q;
        op_d = op_q;
        if (adv[1]) begin
            v_d[1]  = in_valid;
            op_d[1] = in_op;
        end
        for (int k = 2; k <= LOG2W; k++) begin
            if (adv[k]) begin
                v_d[k]  = v_q[k-1];
                op_d[k] = op_q[k-1];
            end
        end
    end

    for (genvar k = 1; k <= LOG2W; k++) begin : g_stage
        localparam int unsigned NB  = WIDTH >> k;
        localparam int unsigned DST = WIDTH - (WIDTH >> (k - 1));

        logic [2*NB-1:0] src;
        logic [1:0]      sop;
        logic [NB-1:0]   red;

        if (k == 1) begin : g_first
            assign src = in_data;
            assign sop = in_op;
        end else begin : g_inner
            localparam int unsigned SRC = WIDTH - (WIDTH >> (k - 2));
            assign src = d_q[SRC +: 2*NB];
            assign sop = op_q[k-1];
        end

        for (genvar i = 0; i < NB; i++) begin : g_bit
            assign red[i] = red2(src[2*i], src[2*i+1], sop);
        end

        assign d_d[DST +: NB] = adv[k] ? red : d_q[DST +: NB];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_q  <= '0;
            v_q  <= '0;
            op_q <= '0;
        end else begin
            d_q  <= d_d;
            v_q  <= v_d;
            op_q <= op_d;
        end
    end

    assign in_ready  = adv[1];
    assign out_valid = v_q[LOG2W];
    assign out_op    = op_q[LOG2W];
    assign out_bit   = (op_q[LOG2W] == 2'b11) ? ~d_q[DW-1] : d_q[DW-1];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Self-checking bench for reduce_tree_pipe: 8-wide instance for directed scenarios and a
// 64-wide instance for randomised traffic, both checked against a queued reference model.
`timescale 1ns/1ps
module tb_reduce_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       b;
        logic [1:0] op;
        int         due;
    } exp_t;

    exp_t q8[$];
    exp_t q64[$];

    logic        rst8, iv8, ir8, ov8, or8, ob8;
    logic [7:0]  id8;
    logic [1:0]  iop8, oop8;
    logic        rst64, iv64, ir64, ov64, or64, ob64;
    logic [63:0] id64;
    logic [1:0]  iop64, oop64;

    reduce_tree_pipe #(.WIDTH(8), .LOG2W(3)) u_dut8 (
        .clock(clk), .reset_n(rst8), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .in_op(iop8), .out_valid(ov8), .out_ready(or8), .out_bit(ob8), .out_op(oop8)
    );

    reduce_tree_pipe #(.WIDTH(64), .LOG2W(6)) u_dut64 (
        .clock(clk), .reset_n(rst64), .in_valid(iv64), .in_ready(ir64), .in_data(id64),
        .in_op(iop64), .out_valid(ov64), .out_ready(or64), .out_bit(ob64), .out_op(oop64)
    );

    function automatic logic model8(input logic [7:0] d, input logic [1:0] op);
        case (op)
            2'b00:   return &d;
            2'b01:   return |d;
            2'b10:   return ^d;
            default: return ~&d;
        endcase
    endfunction

    function automatic logic model64(input logic [63:0] d, input logic [1:0] op);
        case (op)
            2'b00:   return &d;
            2'b01:   return |d;
            2'b10:   return ^d;
            default: return ~&d;
        endcase
    endfunction

    // Output scoreboards: compare every valid output against the queue head, pop on transfer.
    always @(negedge clk) begin
        if (rst8 && ov8) begin
            checks++;
            if (q8.size() == 0) begin
                failures++;
                $display("FAIL w8_spurious: got out_valid=1 out_bit=%0b, required out_valid=0", ob8);
            end else begin
                if (ob8 !== q8[0].b || oop8 !== q8[0].op) begin
                    failures++;
                    $display("FAIL w8_result: got bit=%0b op=%0d, required bit=%0b op=%0d",
                             ob8, oop8, q8[0].b, q8[0].op);
                end else if (q8[0].due >= 0 && cyc != q8[0].due) begin
                    failures++;
                    $display("FAIL w8_latency: got cycle=%0d, required cycle=%0d", cyc, q8[0].due);
                end
                if (or8) void'(q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst64 && ov64) begin
            checks++;
            if (q64.size() == 0) begin
                failures++;
                $display("FAIL w64_spurious: got out_valid=1 out_bit=%0b, required out_valid=0", ob64);
            end else begin
                if (ob64 !== q64[0].b || oop64 !== q64[0].op) begin
                    failures++;
                    $display("FAIL w64_result: got bit=%0b op=%0d, required bit=%0b op=%0d",
                             ob64, oop64, q64[0].b, q64[0].op);
                end else if (q64[0].due >= 0 && cyc != q64[0].due) begin
                    failures++;
                    $display("FAIL w64_latency: got cycle=%0d, required cycle=%0d", cyc, q64[0].due);
                end
                if (or64) void'(q64.pop_front());
            end
        end
    end

    task automatic send8(input logic [7:0] d, input logic [1:0] op, input bit timed);
        bit done = 1'b0;
        iv8  = 1'b1;
        id8  = d;
        iop8 = op;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (ir8) begin
                q8.push_back('{b: model8(d, op), op: op, due: timed ? cyc + 3 : -1});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL w8_send_timeout: got in_ready=0 for 50 cycles, required acceptance");
        end
    endtask

    task automatic send64(input logic [63:0] d, input logic [1:0] op, input bit timed);
        bit done = 1'b0;
        iv64  = 1'b1;
        id64  = d;
        iop64 = op;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (ir64) begin
                q64.push_back('{b: model64(d, op), op: op, due: timed ? cyc + 6 : -1});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        iv64 = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL w64_send_timeout: got in_ready=0 for 50 cycles, required acceptance");
        end
    endtask

    task automatic test_reset();
        rst8 = 1'b0; rst64 = 1'b0;
        iv8 = 1'b0; id8 = '0; iop8 = '0; or8 = 1'b1;
        iv64 = 1'b0; id64 = '0; iop64 = '0; or64 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b1; rst64 = 1'b1;
        checks++;
        if ({ov8, ob8, oop8, ir8} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_state: got {valid,bit,op,ready}=%b, required 00001",
                     {ov8, ob8, oop8, ir8});
        end
        // Three items in flight, held by a stalled consumer, then reset mid-cycle.
        or8 = 1'b0;
        send8(8'hFF, 2'b00, 1'b0);
        send8(8'hFF, 2'b01, 1'b0);
        send8(8'h0F, 2'b10, 1'b0);
        checks++;
        if (ov8 !== 1'b1 || ob8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefill: got valid=%0b bit=%0b, required valid=1 bit=1", ov8, ob8);
        end
        #1 rst8 = 1'b0;
        #1;
        q8.delete();
        checks++;
        if ({ov8, ob8, oop8, ir8} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_async: got {valid,bit,op,ready}=%b, required 00001",
                     {ov8, ob8, oop8, ir8});
        end
        repeat (2) @(posedge clk);
        #2 rst8 = 1'b1;
        or8 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_no_stale: got valid=%0b ready=%0b, required valid=0 ready=1",
                     ov8, ir8);
        end
    endtask

    task automatic test_ops();
        or8 = 1'b1;
        send8(8'hFF, 2'b00, 1'b1);
        send8(8'hFE, 2'b00, 1'b1);
        send8(8'h00, 2'b01, 1'b1);
        send8(8'h80, 2'b01, 1'b1);
        send8(8'h07, 2'b10, 1'b1);
        send8(8'h03, 2'b10, 1'b1);
        send8(8'hFF, 2'b11, 1'b1);
        for (int n = 0; n < 20 && q8.size() > 0; n++) @(posedge clk);
        #1;
        checks++;
        if (q8.size() != 0) begin
            failures++;
            $display("FAIL ops_drain: got %0d results missing, required 0", q8.size());
        end
    endtask

    task automatic test_back_pressure();
        int sent = 0;
        for (int t = 0; t < 60 && (sent < 6 || q8.size() > 0); t++) begin
            or8  = (t < 2 || t >= 9);
            iv8  = (sent < 6);
            id8  = 8'(t * 37 + 5);
            iop8 = 2'(t);
            @(negedge clk);
            if (t == 7) begin
                checks++;
                if (ir8 !== 1'b0 || ov8 !== 1'b1 || sent != 3) begin
                    failures++;
                    $display("FAIL bp_stall: got ready=%0b valid=%0b accepted=%0d, required 0 1 3",
                             ir8, ov8, sent);
                end
            end
            if (iv8 && ir8) begin
                q8.push_back('{b: model8(id8, iop8), op: iop8, due: -1});
                sent++;
            end
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        checks++;
        if (sent != 6 || q8.size() != 0) begin
            failures++;
            $display("FAIL bp_drain: got accepted=%0d pending=%0d, required 6 0", sent, q8.size());
        end
    endtask

    task automatic test_bubbles();
        logic [5:0] pat = 6'b100101;
        for (int t = 0; t < 10; t++) begin
            or8  = 1'b0;
            iv8  = (t < 6) ? pat[t] : 1'b0;
            id8  = 8'(t * 73 + 1);
            iop8 = 2'(t + 1);
            @(negedge clk);
            if (t == 9) begin
                checks++;
                if (ir8 !== 1'b0 || ov8 !== 1'b1 || q8.size() != 3) begin
                    failures++;
                    $display("FAIL bubble_compact: got ready=%0b valid=%0b queued=%0d, required 0 1 3",
                             ir8, ov8, q8.size());
                end
            end
            if (iv8 && ir8) q8.push_back('{b: model8(id8, iop8), op: iop8, due: -1});
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        for (int n = 0; n < 20 && q8.size() > 0; n++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (q8.size() != 0 || ov8 !== 1'b0) begin
            failures++;
            $display("FAIL bubble_drain: got pending=%0d valid=%0b, required 0 0", q8.size(), ov8);
        end
    endtask

    task automatic test_simultaneous();
        or8 = 1'b0;
        send8(8'hAA, 2'b10, 1'b0);
        send8(8'h7F, 2'b11, 1'b0);
        send8(8'h01, 2'b01, 1'b0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!ir8) break;
        end
        @(posedge clk); #1;
        iv8 = 1'b1; id8 = 8'hC3; iop8 = 2'b10; or8 = 1'b1;
        @(negedge clk);
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL simul_ready: got ready=%0b valid=%0b, required 1 1", ir8, ov8);
        end
        if (ir8) q8.push_back('{b: model8(id8, iop8), op: iop8, due: -1});
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b0;
        @(negedge clk);
        checks++;
        if (ir8 !== 1'b0 || ov8 !== 1'b1 || q8.size() != 3) begin
            failures++;
            $display("FAIL simul_occupancy: got ready=%0b valid=%0b queued=%0d, required 0 1 3",
                     ir8, ov8, q8.size());
        end
        @(posedge clk); #1;
        or8 = 1'b1;
        for (int n = 0; n < 20 && q8.size() > 0; n++) @(posedge clk);
        #1;
        checks++;
        if (q8.size() != 0) begin
            failures++;
            $display("FAIL simul_drain: got pending=%0d, required 0", q8.size());
        end
    endtask

    task automatic test_random64();
        int acc = 0;
        or64 = 1'b1;
        send64({64{1'b1}}, 2'b00, 1'b1);
        send64(64'h1, 2'b01, 1'b1);
        send64(64'h8000_0000_0000_0001, 2'b10, 1'b1);
        send64({64{1'b1}}, 2'b11, 1'b1);
        send64(64'h0, 2'b11, 1'b1);
        send64(64'h0100_0000_0000_0000, 2'b10, 1'b1);
        for (int n = 0; n < 30 && q64.size() > 0; n++) @(posedge clk);
        #1;
        for (int n = 0; n < 20000 && acc < 1000; n++) begin
            iv64  = ($urandom_range(3) != 0);
            case ($urandom_range(3))
                0:       id64 = {64{1'b1}};
                1:       id64 = {$urandom(), $urandom()} | 64'hFFFF_FFFF_FFFF_FFF0;
                default: id64 = {$urandom(), $urandom()};
            endcase
            iop64 = 2'($urandom_range(3));
            or64  = ($urandom_range(2) != 0);
            @(negedge clk);
            if (iv64 && ir64) begin
                q64.push_back('{b: model64(id64, iop64), op: iop64, due: -1});
                acc++;
            end
            @(posedge clk); #1;
        end
        iv64 = 1'b0;
        or64 = 1'b1;
        for (int n = 0; n < 50 && q64.size() > 0; n++) @(posedge clk);
        #1;
        checks++;
        if (acc != 1000 || q64.size() != 0) begin
            failures++;
            $display("FAIL w64_random: got accepted=%0d pending=%0d, required 1000 0",
                     acc, q64.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by 2ms, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ops();
        test_back_pressure();
        test_bubbles();
        test_simultaneous();
        test_random64();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
